// File: rtl/udl_key_ctrl.sv
// udl_key_ctrl
//   Front end that turns three raw DE1-SoC pushbuttons into the one-cycle
//   control strobes of the up/down/loadable counter. Keys are synchronised,
//   debounced, and edge-detected. A held up/down key auto-repeats: the first
//   repeat comes RPT_DLY cycles after the first step, then one every RPT_PER.
//
// Ports
//   clk       in   system clock (only clock)
//   rst       in   synchronous active-high reset
//   key_up_n  in   raw up key, active-low, asynchronous
//   key_dn_n  in   raw down key, active-low, asynchronous
//   key_ld_n  in   raw load key, active-low, asynchronous
//   en        out  one-cycle strobe; the counter acts while it is high
//   d_nu      out  1 = count down (only with en)
//   pl        out  1 = parallel load (only with en)
//   key_dbn   out  debounced pressed levels {ld,dn,up}, active-high
//
// state    | meaning
// IDLE     | waiting for a fresh press
// HOLD_DLY | stepped once, timing the hold delay before repeating
// REPEAT   | auto-repeating every RPT_PER cycles
// WAIT_REL | load or conflicting press seen; wait until all keys released

module udl_key_ctrl #(
  parameter int DEB_CYC = 50000,
  parameter int RPT_DLY = 25000000,
  parameter int RPT_PER = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       key_ld_n,
  output logic       en,
  output logic       d_nu,
  output logic       pl,
  output logic [2:0] key_dbn
);

  localparam int DW      = $clog2(DEB_CYC);
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int TW      = $clog2(RPT_MAX);

  localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] DLY_TC = TW'(RPT_DLY - 1);
  localparam logic [TW-1:0] PER_TC = TW'(RPT_PER - 1);

  typedef enum logic [1:0] {IDLE, HOLD_DLY, REPEAT, WAIT_REL} state_t;

  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         lvl;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]         dbn_q, dbn_d;
  logic [2:0]         dbn_prev_q;
  logic [2:0]         press;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               dir_q, dir_d;
  logic               en_q, en_d;
  logic               d_nu_q, d_nu_d;
  logic               pl_q, pl_d;

  logic               held, opp;
  logic [TW-1:0]      tc;

  // Bit order everywhere: 0 = up, 1 = down, 2 = load.
  assign lvl   = ~sync2_q;
  assign press = dbn_q & ~dbn_prev_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dbn_d[i]     = dbn_q[i];
      deb_cnt_d[i] = '0;
      if (lvl[i] != dbn_q[i]) begin
        if (deb_cnt_q[i] == DEB_TC) begin
          dbn_d[i] = lvl[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // dir_q: 0 = up, 1 = down. "held" is the latched key, "opp" the other one.
  assign held = dir_q ? dbn_q[1] : dbn_q[0];
  assign opp  = dir_q ? dbn_q[0] : dbn_q[1];
  assign tc   = (state_q == HOLD_DLY) ? DLY_TC : PER_TC;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    en_d    = 1'b0;
    d_nu_d  = 1'b0;
    pl_d    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (press[2]) begin
          en_d    = 1'b1;
          pl_d    = 1'b1;
          state_d = WAIT_REL;
        end else if (press[0] && press[1]) begin
          state_d = WAIT_REL;
        end else if (press[0]) begin
          en_d    = 1'b1;
          dir_d   = 1'b0;
          state_d = HOLD_DLY;
        end else if (press[1]) begin
          en_d    = 1'b1;
          d_nu_d  = 1'b1;
          dir_d   = 1'b1;
          state_d = HOLD_DLY;
        end
      end
      HOLD_DLY, REPEAT: begin
        if (press[2]) begin
          en_d    = 1'b1;
          pl_d    = 1'b1;
          timer_d = '0;
          state_d = WAIT_REL;
        end else if (opp) begin
          timer_d = '0;
          state_d = WAIT_REL;
        end else if (!held) begin
          // Release beats a coincident terminal count.
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == tc) begin
          en_d    = 1'b1;
          d_nu_d  = dir_q;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_REL: begin
        timer_d = '0;
        if (dbn_q == 3'b000) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      deb_cnt_q  <= '0;
      dbn_q      <= 3'b000;
      dbn_prev_q <= 3'b000;
      state_q    <= IDLE;
      timer_q    <= '0;
      dir_q      <= 1'b0;
      en_q       <= 1'b0;
      d_nu_q     <= 1'b0;
      pl_q       <= 1'b0;
    end else begin
      sync1_q    <= {key_ld_n, key_dn_n, key_up_n};
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      dbn_q      <= dbn_d;
      dbn_prev_q <= dbn_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      d_nu_q     <= d_nu_d;
      pl_q       <= pl_d;
    end
  end

  assign en      = en_q;
  assign d_nu    = d_nu_q;
  assign pl      = pl_q;
  assign key_dbn = dbn_q;

endmodule

// File: tb/tb_udl_key_ctrl.sv
module tb_udl_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_up_n, key_dn_n, key_ld_n;
  logic       en, d_nu, pl;
  logic [2:0] key_dbn;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int inv_err = 0;
  logic [2:0] dbn_seen = 3'b000;

  int exp_t[$];
  bit exp_d[$];
  bit exp_p[$];
  int en_t[$];
  bit en_d[$];
  bit en_p[$];

  udl_key_ctrl #(.DEB_CYC(4), .RPT_DLY(20), .RPT_PER(8)) dut (
    .clk(clk), .rst(rst),
    .key_up_n(key_up_n), .key_dn_n(key_dn_n), .key_ld_n(key_ld_n),
    .en(en), .d_nu(d_nu), .pl(pl), .key_dbn(key_dbn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Strobes are logged with the number of the edge that raised them.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_t.push_back(edge_n);
      en_d.push_back(d_nu);
      en_p.push_back(pl);
    end
    if ((pl === 1'b1 && d_nu === 1'b1) || ((pl === 1'b1 || d_nu === 1'b1) && en !== 1'b1))
      inv_err++;
    dbn_seen = dbn_seen | key_dbn;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    en_t.delete(); en_d.delete(); en_p.delete();
    exp_t.delete(); exp_d.delete(); exp_p.delete();
    dbn_seen = 3'b000;
  endtask

  task automatic expect_strobe(input int t, input bit dn, input bit ld);
    exp_t.push_back(t); exp_d.push_back(dn); exp_p.push_back(ld);
  endtask

  task automatic check_strobes(input string tag, input int t0);
    chk($sformatf("%s_count", tag), en_t.size(), exp_t.size());
    foreach (exp_t[i]) begin
      if (i < en_t.size()) begin
        chk($sformatf("%s_t%0d", tag, i), en_t[i] - t0, exp_t[i]);
        chk($sformatf("%s_dnu%0d", tag, i), int'(en_d[i]), int'(exp_d[i]));
        chk($sformatf("%s_pl%0d", tag, i), int'(en_p[i]), int'(exp_p[i]));
      end
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; key_up_n = 1'b0; key_dn_n = 1'b1; key_ld_n = 1'b1;

    // Reset held with up pressed: everything stays quiet.
    repeat (3) begin
      cyc(1);
      chk("rst_out", int'({en, d_nu, pl, key_dbn}), 0);
    end
    clr();
    rst = 1'b0;
    t0 = edge_n;
    cyc(12);
    key_up_n = 1'b1;
    cyc(15);
    expect_strobe(7, 1'b0, 1'b0);
    check_strobes("rst_first", t0);

    // 3-cycle glitch: filtered out entirely.
    clr();
    key_up_n = 1'b0;
    cyc(3);
    key_up_n = 1'b1;
    cyc(15);
    chk("glitch_en", en_t.size(), 0);
    chk("glitch_dbn", int'(dbn_seen), 0);

    // 4-cycle pulse: just long enough for one step.
    clr();
    t0 = edge_n;
    key_up_n = 1'b0;
    cyc(4);
    key_up_n = 1'b1;
    cyc(25);
    chk("pulse4_dbn", int'(dbn_seen), 1);
    expect_strobe(7, 1'b0, 1'b0);
    check_strobes("pulse4", t0);

    // Down held 60 cycles: first step, hold delay, then repeats.
    clr();
    t0 = edge_n;
    key_dn_n = 1'b0;
    cyc(60);
    key_dn_n = 1'b1;
    cyc(30);
    expect_strobe(7, 1'b1, 1'b0);
    expect_strobe(27, 1'b1, 1'b0);
    expect_strobe(35, 1'b1, 1'b0);
    expect_strobe(43, 1'b1, 1'b0);
    expect_strobe(51, 1'b1, 1'b0);
    expect_strobe(59, 1'b1, 1'b0);
    check_strobes("dn_hold", t0);

    // Load during up repeat: one load, then silence while up stays held.
    clr();
    t0 = edge_n;
    key_up_n = 1'b0;
    cyc(27);
    key_ld_n = 1'b0;
    cyc(10);
    key_ld_n = 1'b1;
    cyc(20);
    key_up_n = 1'b1;
    cyc(15);
    expect_strobe(7, 1'b0, 1'b0);
    expect_strobe(27, 1'b0, 1'b0);
    expect_strobe(34, 1'b0, 1'b1);
    check_strobes("load_rpt", t0);

    clr();
    t0 = edge_n;
    key_up_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    cyc(15);
    expect_strobe(7, 1'b0, 1'b0);
    check_strobes("after_load", t0);

    // Up and down together: no strobe, then a clean up press works.
    clr();
    key_up_n = 1'b0; key_dn_n = 1'b0;
    cyc(40);
    key_up_n = 1'b1; key_dn_n = 1'b1;
    cyc(15);
    chk("conflict_en", en_t.size(), 0);
    chk("conflict_dbn", int'(dbn_seen), 3);

    clr();
    t0 = edge_n;
    key_up_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    cyc(15);
    expect_strobe(7, 1'b0, 1'b0);
    check_strobes("after_conf", t0);

    // Reset while repeating down: fresh debounce and hold delay afterwards.
    clr();
    key_dn_n = 1'b0;
    cyc(30);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_out", int'({en, d_nu, pl, key_dbn}), 0);
    clr();
    t0 = edge_n;
    cyc(28);
    key_dn_n = 1'b1;
    cyc(20);
    expect_strobe(7, 1'b1, 1'b0);
    expect_strobe(27, 1'b1, 1'b0);
    check_strobes("midrst", t0);

    chk("invariant", inv_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
